// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state and output-mode types for the SAR ADC controller
package adc_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

  // DAC path selection, shared with output_mode_fsm; bit order matches {r2r_enable, pwm_enable}
  typedef enum logic [1:0] {
    OFF_MODE = 2'b00,
    PWM_MODE = 2'b01,
    R2R_MODE = 2'b10
  } out_mode_t;

  // A mode is usable only when exactly one DAC path is enabled
  function automatic logic mode_is_valid(input logic [1:0] m);
    return (m == PWM_MODE) || (m == R2R_MODE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve metastability
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller driving the PWM or R2R DAC
module sar_adc_ctrl
  import adc_pkg::*;
#(
  parameter int W          = 8,
  parameter int R2R_SETTLE = 4,
  parameter int PWM_SETTLE = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_enable,
  input  logic         r2r_enable,
  input  logic         comp_in,
  output logic [W-1:0] dac_code,
  output logic         busy,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic [1:0]   result_mode
);

  localparam int MAX_S = (R2R_SETTLE > PWM_SETTLE) ? R2R_SETTLE : PWM_SETTLE;
  localparam int CNT_W = (MAX_S > 2) ? $clog2(MAX_S) : 1;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [CNT_W-1:0] R2R_RELOAD = CNT_W'(R2R_SETTLE - 1);
  localparam logic [CNT_W-1:0] PWM_RELOAD = CNT_W'(PWM_SETTLE - 1);
  localparam logic [IDX_W-1:0] MSB_IDX    = IDX_W'(W - 1);
  localparam logic [W-1:0]     MSB_CODE   = W'(1) << (W - 1);

  sar_state_t       state_q, state_d;
  out_mode_t        mode_q, mode_d;
  out_mode_t        result_mode_q, result_mode_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     dac_q, dac_d;
  logic [W-1:0]     result_q, result_d;
  logic             valid_q, valid_d;
  logic [1:0]       mode_in;
  logic             comp_sync;
  logic             abort;
  logic [W-1:0]     code;

  sync_2ff u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comp_in),
    .q     (comp_sync)
  );

  assign mode_in      = {r2r_enable, pwm_enable};
  assign abort        = (mode_in != mode_q);
  assign dac_code     = dac_q;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign result_mode  = result_mode_q;

  // State and datapath registers; everything clears to zero / IDLE on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= OFF_MODE;
      result_mode_q <= OFF_MODE;
      reload_q      <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      dac_q         <= '0;
      result_q      <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      result_mode_q <= result_mode_d;
      reload_q      <= reload_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      dac_q         <= dac_d;
      result_q      <= result_d;
      valid_q       <= valid_d;
    end
  end

  // Sequencer: trial-bit walk from MSB to LSB, each code held for the latched settle time
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    result_mode_d = result_mode_q;
    reload_d      = reload_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    dac_d         = dac_q;
    result_d      = result_q;
    valid_d       = 1'b0;
    code          = dac_q;

    case (state_q)
      IDLE: begin
        dac_d = '0;
        if (mode_is_valid(mode_in)) begin
          mode_d   = out_mode_t'(mode_in);
          reload_d = (mode_in == R2R_MODE) ? R2R_RELOAD : PWM_RELOAD;
          cnt_d    = (mode_in == R2R_MODE) ? R2R_RELOAD : PWM_RELOAD;
          idx_d    = MSB_IDX;
          dac_d    = MSB_CODE;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          dac_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      COMPARE: begin
        if (abort) begin
          dac_d   = '0;
          state_d = IDLE;
        end else begin
          // Comparator low means the trial code overshot Vin: drop this bit
          if (!comp_sync) begin
            code[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            result_d      = code;
            result_mode_d = mode_q;
            valid_d       = 1'b1;
            state_d       = DONE;
          end else begin
            code[idx_q - 1'b1] = 1'b1;
            idx_d              = idx_q - 1'b1;
            cnt_d              = reload_q;
            state_d            = SETTLE;
          end
          dac_d = code;
        end
      end

      DONE: begin
        dac_d   = '0;
        state_d = IDLE;
      end

      default: begin
        dac_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl
module tb_sar_adc_ctrl;

  logic       clk;
  logic       reset;
  logic       pwm_enable;
  logic       r2r_enable;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic [1:0] result_mode;

  typedef struct {
    logic [7:0] res;
    logic [1:0] mode;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         comp_sel;
  logic [7:0] vin;
  logic [7:0] last_res;
  logic [1:0] last_mode;

  sar_adc_ctrl #(.W(8), .R2R_SETTLE(4), .PWM_SETTLE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .pwm_enable   (pwm_enable),
    .r2r_enable   (r2r_enable),
    .comp_in      (comp_in),
    .dac_code     (dac_code),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_mode  (result_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: Vin sits half an LSB above its code, so a trial equal to Vin is kept
  always_comb begin
    case (comp_sel)
      0:       comp_in = ({vin, 1'b1} > {dac_code, 1'b0});
      1:       comp_in = 1'b1;
      default: comp_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("result_mode", result_mode, e.mode);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // One conversion from IDLE; cycle 0 is the cycle the enable is first seen
  task automatic run_conv(input logic r2r, input logic pwm, input int s, input logic [7:0] exp);
    int c;
    int lat;
    exp_t e;
    lat = 8 * (s + 1) + 1;
    r2r_enable = r2r;
    pwm_enable = pwm;
    c = cyc;
    e.res = exp; e.mode = {r2r, pwm}; e.cyc = c + lat;
    sb.push_back(e);
    check("busy_cycle0", busy, 0);
    wait_cyc(c + 1);
    check("busy_cycle1", busy, 1);
    wait_cyc(c + lat);
    check("busy_done", busy, 1);
    check("dac_done", dac_code, exp);
    wait_cyc(c + lat + 1);
    r2r_enable = 1'b0;
    pwm_enable = 1'b0;
    check("busy_after", busy, 0);
    check("dac_after", dac_code, 0);
    last_res  = exp;
    last_mode = {r2r, pwm};
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int busy_seen;
    int dac_seen;
    exp_t e;

    reset = 1'b1; pwm_enable = 1'b0; r2r_enable = 1'b0;
    comp_sel = 0; vin = 8'h00; last_res = 8'h00; last_mode = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_dac", dac_code, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_mode", result_mode, 0);
    reset = 1'b0;
    @(negedge clk);

    // R2R and PWM conversions against the comparator model
    vin = 8'hA5;
    run_conv(1'b1, 1'b0, 4, 8'hA5);
    vin = 8'h3C;
    run_conv(1'b0, 1'b1, 16, 8'h3C);

    // Stuck comparator extremes
    comp_sel = 2;
    run_conv(1'b1, 1'b0, 4, 8'h00);
    comp_sel = 1;
    r2r_enable = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      e.res = 8'hFF; e.mode = 2'b10; e.cyc = c + 41 + 42 * k;
      sb.push_back(e);
    end
    wait_cyc(c + 42);
    check("b2b_idle_gap", busy, 0);
    wait_cyc(c + 43);
    check("b2b_restart", busy, 1);
    wait_cyc(c + 126);
    r2r_enable = 1'b0;
    last_res = 8'hFF; last_mode = 2'b10;
    wait_cyc(c + 127);
    check("b2b_stop", busy, 0);

    // Mode switch mid-conversion aborts, then PWM restarts from IDLE
    comp_sel = 0;
    vin = 8'h5A;
    r2r_enable = 1'b1;
    c = cyc;
    wait_cyc(c + 20);
    r2r_enable = 1'b0;
    pwm_enable = 1'b1;
    wait_cyc(c + 21);
    check("abort_dac", dac_code, 0);
    check("abort_busy", busy, 0);
    check("abort_result_held", result, last_res);
    check("abort_mode_held", result_mode, last_mode);
    e.res = 8'h5A; e.mode = 2'b01; e.cyc = c + 21 + 137;
    sb.push_back(e);
    wait_cyc(c + 21 + 138);
    pwm_enable = 1'b0;
    last_res = 8'h5A; last_mode = 2'b01;
    @(negedge clk);

    // Both enables high: never starts
    r2r_enable = 1'b1;
    pwm_enable = 1'b1;
    busy_seen = 0;
    dac_seen  = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (dac_code != 8'h00) dac_seen++;
    end
    check("both_busy_cycles", busy_seen, 0);
    check("both_dac_cycles", dac_seen, 0);
    check("both_result_held", result, last_res);
    r2r_enable = 1'b0;
    pwm_enable = 1'b0;
    @(negedge clk);

    // Reset mid-conversion, then a fresh conversion
    vin = 8'h77;
    r2r_enable = 1'b1;
    c = cyc;
    wait_cyc(c + 15);
    reset = 1'b1;
    r2r_enable = 1'b0;
    wait_cyc(c + 16);
    check("midrst_dac", dac_code, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_mode", result_mode, 0);
    reset = 1'b0;
    @(negedge clk);
    run_conv(1'b1, 1'b0, 4, 8'h77);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
